// File: rtl/mul_accumulate.sv
// Accumulates a stream of unsigned products into groups closed by in_last and queues
// {sum, count, overflow} per group in a 2-entry result FIFO. Optional macro: MUL_ACCUMULATE_SAT_EN.
module mul_accumulate #(
   parameter int W     = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [W-1:0]     in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             err_drop
);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state, state_nxt;
   logic [W-1:0]     acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic [W:0]       sum_ext;
   logic             first, push, pop, full, push_ok;

   logic [W-1:0]     sum_mem [2];
   logic [CNT_W-1:0] cnt_mem [2];
   logic             ovf_mem [2];
   logic             rd_ptr, wr_ptr;
   logic [1:0]       level;

   // State register plus the group datapath registers it qualifies
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_valid) begin
            acc <= in_last ? '0   : acc_nxt;
            cnt <= in_last ? '0   : cnt_nxt;
            ovf <= in_last ? 1'b0 : ovf_nxt;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (in_valid)
         state_nxt = in_last ? IDLE : ACCUM;
   end

   always_comb begin
      first   = (state == IDLE);
      push    = in_valid & in_last;
      sum_ext = {1'b0, (first ? {W{1'b0}} : acc)} + {1'b0, in_product};
      ovf_nxt = (first ? 1'b0 : ovf) | sum_ext[W];
`ifdef MUL_ACCUMULATE_SAT_EN
      // Once the group has carried out, pin the sum at all-ones until it closes
      acc_nxt = ovf_nxt ? {W{1'b1}} : sum_ext[W-1:0];
`else
      acc_nxt = sum_ext[W-1:0];
`endif
      if (first)               cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt == CNT_MAX) cnt_nxt = cnt;
      else                     cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign out_valid = (level != 2'd0);
   assign pop       = out_valid & out_ready;
   assign full      = (level == 2'd2);
   // A pop frees the slot in the same edge, so a full FIFO still takes the push
   assign push_ok   = push & (!full | pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            sum_mem[i] <= '0;
            cnt_mem[i] <= '0;
            ovf_mem[i] <= 1'b0;
         end
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         level    <= 2'd0;
         err_drop <= 1'b0;
      end else begin
         if (push_ok) begin
            sum_mem[wr_ptr] <= acc_nxt;
            cnt_mem[wr_ptr] <= cnt_nxt;
            ovf_mem[wr_ptr] <= ovf_nxt;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         level <= level + {1'b0, push_ok} - {1'b0, pop};
         if (push & full & !pop)
            err_drop <= 1'b1;
      end
   end

   assign out_sum   = sum_mem[rd_ptr];
   assign out_count = cnt_mem[rd_ptr];
   assign out_ovf   = ovf_mem[rd_ptr];

endmodule

// File: tb/tb_mul_accumulate.sv
// Bench for mul_accumulate: vector table, directed corner sequences, and random traffic
// against a group-level model (exact wide sums, queue FIFO). Honours MUL_ACCUMULATE_SAT_EN.
module tb_mul_accumulate;
   localparam int W  = 64;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef MUL_ACCUMULATE_SAT_EN
   localparam logic [W-1:0] OVF_SUM = {W{1'b1}};
`else
   localparam logic [W-1:0] OVF_SUM = 64'd1;
`endif

   logic          clk = 1'b0, reset = 1'b0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [W-1:0]  in_product = '0;
   logic          out_valid, out_ovf, err_drop;
   logic [W-1:0]  out_sum;
   logic [CW-1:0] out_count;

   mul_accumulate #(.W(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_product(in_product),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf), .err_drop(err_drop));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   typedef struct {logic [W-1:0] sum; int cnt; logic ovf;} ent_t;
   ent_t         mq[$];
   logic         m_open = 1'b0;
   logic [127:0] m_tot  = '0;
   int           m_n    = 0;
   logic         m_err  = 1'b0;

   typedef struct {
      logic v; logic [W-1:0] p; logic l; logic r;
      logic ev; logic [W-1:0] es; int ec; logic eo;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Group-level reference: exact sum of the group, overflow iff it exceeds W bits
   task automatic model_edge();
      ent_t e;
      logic pop;
      if (!reset) begin
         mq.delete(); m_open = 1'b0; m_tot = '0; m_n = 0; m_err = 1'b0;
         return;
      end
      pop = (mq.size() > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (in_valid) begin
         if (!m_open) begin m_tot = 128'(in_product); m_n = 1; end
         else begin m_tot = m_tot + 128'(in_product); m_n++; end
         m_open = !in_last;
         if (in_last) begin
            e.ovf = (m_tot[127:W] != 0);
`ifdef MUL_ACCUMULATE_SAT_EN
            e.sum = e.ovf ? {W{1'b1}} : m_tot[W-1:0];
`else
            e.sum = m_tot[W-1:0];
`endif
            e.cnt = (m_n > CMAX) ? CMAX : m_n;
            if (mq.size() < 2) mq.push_back(e);
            else m_err = 1'b1;
         end
      end
   endtask

   task automatic model_chk();
      chk("m_valid", W'(out_valid), W'(mq.size() > 0));
      chk("m_err", W'(err_drop), W'(m_err));
      if (mq.size() > 0) begin
         chk("m_sum", out_sum, mq[0].sum);
         chk("m_count", W'(out_count), W'(mq[0].cnt));
         chk("m_ovf", W'(out_ovf), W'(mq[0].ovf));
      end
   endtask

   task automatic step(input logic v, input logic [W-1:0] p, input logic l, input logic r);
      in_valid = v; in_product = p; in_last = l; out_ready = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input logic v);
      reset = 1'b0;
      step(v, 64'd9, 1'b0, 1'b1);
      reset = 1'b1;
   endtask

   task automatic head(input string nm, input logic [W-1:0] s, input int c, input logic o);
      chk({nm, "_valid"}, W'(out_valid), 64'd1);
      chk({nm, "_sum"}, out_sum, s);
      chk({nm, "_count"}, W'(out_count), W'(c));
      chk({nm, "_ovf"}, W'(out_ovf), W'(o));
   endtask

   initial begin
      logic [W-1:0] p;
      tbl[0]  = '{1'b1, 64'd3,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[1]  = '{1'b1, 64'd5,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[2]  = '{1'b1, 64'd7,  1'b1, 1'b1, 1'b1, 64'd15, 3, 1'b0};
      tbl[3]  = '{1'b0, 64'd0,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[4]  = '{1'b1, 64'h2A, 1'b1, 1'b1, 1'b1, 64'h2A, 1, 1'b0};
      tbl[5]  = '{1'b0, 64'd0,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[6]  = '{1'b1, 64'd4,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[7]  = '{1'b0, 64'd77, 1'b1, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[8]  = '{1'b0, 64'd0,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[9]  = '{1'b1, 64'd6,  1'b1, 1'b1, 1'b1, 64'd10, 2, 1'b0};
      tbl[10] = '{1'b0, 64'd0,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};
      tbl[11] = '{1'b1, {W{1'b1}}, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0};
      tbl[12] = '{1'b1, 64'd2,  1'b1, 1'b1, 1'b1, OVF_SUM, 2, 1'b1};
      tbl[13] = '{1'b0, 64'd0,  1'b0, 1'b1, 1'b0, 64'd0,  0, 1'b0};

      do_reset(1'b1);
      chk("rst_valid", W'(out_valid), 64'd0);
      chk("rst_sum", out_sum, 64'd0);
      chk("rst_count", W'(out_count), 64'd0);
      chk("rst_ovf", W'(out_ovf), 64'd0);
      chk("rst_err", W'(err_drop), 64'd0);

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r);
         chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].ev));
         if (tbl[i].ev) head($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, tbl[i].eo);
      end

      // Full FIFO with no consumer: third group is dropped, head holds stable
      step(1'b1, 64'd1, 1'b1, 1'b0); head("f1", 64'd1, 1, 1'b0);
      step(1'b1, 64'd2, 1'b1, 1'b0); head("f2_hold", 64'd1, 1, 1'b0);
      step(1'b1, 64'd3, 1'b1, 1'b0); head("f3_hold", 64'd1, 1, 1'b0);
      chk("drop_err", W'(err_drop), 64'd1);
      step(1'b0, 64'd0, 1'b0, 1'b1); head("drain2", 64'd2, 1, 1'b0);
      step(1'b0, 64'd0, 1'b0, 1'b1); chk("drained", W'(out_valid), 64'd0);

      // Push and pop on the same edge while full
      step(1'b1, 64'd4, 1'b1, 1'b0);
      step(1'b1, 64'd5, 1'b1, 1'b0);
      step(1'b1, 64'd6, 1'b1, 1'b1); head("pp_head", 64'd5, 1, 1'b0);
      step(1'b0, 64'd0, 1'b0, 1'b1); head("pp_next", 64'd6, 1, 1'b0);
      step(1'b0, 64'd0, 1'b0, 1'b1); chk("pp_empty", W'(out_valid), 64'd0);
      chk("pp_err_sticky", W'(err_drop), 64'd1);

      // Reset in the middle of an open group
      step(1'b1, 64'd9, 1'b0, 1'b1);
      step(1'b1, 64'd9, 1'b0, 1'b1);
      do_reset(1'b1);
      chk("mid_rst_valid", W'(out_valid), 64'd0);
      chk("mid_rst_err", W'(err_drop), 64'd0);
      step(1'b1, 64'd1, 1'b1, 1'b1); head("post_rst", 64'd1, 1, 1'b0);
      step(1'b0, 64'd0, 1'b0, 1'b1);

      // Counter saturation with a 17-word group
      for (int i = 0; i < 17; i++) step(1'b1, 64'd1, (i == 16), 1'b0);
      head("cnt_sat", 64'd17, CMAX, 1'b0);
      step(1'b0, 64'd0, 1'b0, 1'b1);

      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(3))
            0: p = 64'($urandom_range(100));
            1: p = {$urandom, $urandom};
            2: p = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(4095));
            default: p = '0;
         endcase
         if ($urandom_range(399) == 0) reset = 1'b0;
         step($urandom_range(9) < 7, p, $urandom_range(7) == 0, $urandom_range(9) < 6);
         reset = 1'b1;
         model_chk();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
